// File: rtl/nts_dispatcher_pkg.sv
// nts_dispatcher_pkg: shared FSM state encoding, keep constant and small
// helpers used by the dispatcher backend and its output buffer.
package nts_dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_READ    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DISCARD = 3'd4
    } backend_state_e;

    // Keep mask carried by every word except the final one of a packet.
    localparam logic [7:0] KEEP_ALL = 8'hff;

    // Output buffer entry: {data[63:0], keep[7:0], last}.
    localparam int OBUF_W = 64 + 8 + 1;

    // Saturating 32-bit increment used by the optional statistics counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/nts_backend_obuf.sv
// nts_backend_obuf: show-ahead synchronous FIFO holding {data, keep, last}
// entries between the dispatcher read port and the engine handshake.
// The occupancy count is a registered output so the read-credit logic in
// the backend never depends on this cycle's push/pop.
module nts_backend_obuf
    import nts_dispatcher_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OBUF_W
) (
    input  logic                   i_clk,
    input  logic                   i_areset,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    // Pointer and occupancy bookkeeping; pushes into a full buffer and pops
    // from an empty one are ignored.
    always_comb begin
        wr_ok    = i_wr_en && (count_q != DEPTH_C);
        rd_ok    = i_rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the buffer.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rd_ptr_q];
    assign o_count   = count_q;
    assign o_empty   = (count_q == '0);

endmodule

// File: rtl/nts_dispatcher_backend.sv
// nts_dispatcher_backend: reads one packet out of the dispatcher buffer,
// streams it to the engine over valid/ready, then releases the buffer with
// a one-cycle discard pulse. Early exhaustion of the dispatcher aborts the
// packet: buffered words are flushed with last forced and o_error pulses.
// Optional feature macro: NTS_DISPATCHER_BACKEND_STATS_EN adds saturating
// packet/abort counters (o_stat_packets, o_stat_aborts).
module nts_dispatcher_backend
    import nts_dispatcher_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_dispatch_packet_available,
    output logic                  o_dispatch_packet_read_discard,
    input  logic [ADDR_WIDTH-1:0] i_dispatch_counter,
    input  logic [7:0]            i_dispatch_data_valid,
    input  logic                  i_dispatch_fifo_empty,
    output logic                  o_dispatch_fifo_rd_en,
    input  logic [63:0]           i_dispatch_fifo_rd_data,
    output logic                  o_engine_valid,
    input  logic                  i_engine_ready,
    output logic [63:0]           o_engine_data,
    output logic [7:0]            o_engine_keep,
    output logic                  o_engine_last,
    output logic                  o_error
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
    ,
    output logic [31:0]           o_stat_packets,
    output logic [31:0]           o_stat_aborts
`endif
);

    localparam int CW = $clog2(OBUF_DEPTH);
    localparam logic [CW:0]         DEPTH_C = (CW+1)'(OBUF_DEPTH);
    localparam logic [CW:0]         OCC_ONE = (CW+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    backend_state_e      state_q, state_d;
    logic [ADDR_WIDTH:0] total_q, total_d;
    logic [ADDR_WIDTH:0] issued_q, issued_d;
    logic [ADDR_WIDTH:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]          mask_q, mask_d;
    logic                aborted_q, aborted_d;
    logic                inflight_q, inflight_d;

    logic                rd_en, abort, credit_ok, beat_fire, drain_done;
    logic                wr_last, force_last;
    logic [7:0]          wr_keep;
    logic [CW:0]         credit_used;
    logic [OBUF_W-1:0]   obuf_wr_data, obuf_rd_data;
    logic [CW:0]         obuf_count;
    logic                obuf_empty;

    // Words already buffered plus the read still in flight must leave room
    // for one more before a new read is issued.
    assign credit_used = obuf_count + {{CW{1'b0}}, inflight_q};
    assign credit_ok   = (credit_used < DEPTH_C);
    assign beat_fire   = !obuf_empty && i_engine_ready;
    // The buffer is empty, or its final entry leaves this cycle, with nothing in flight.
    assign drain_done  = !inflight_q &&
                         ((obuf_count == '0) || ((obuf_count == OCC_ONE) && beat_fire));

    // Next-state and per-cycle controls of the packet FSM.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_dispatch_packet_available) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                if (issued_q == total_q) begin
                    state_d = ST_DRAIN;
                end else if (i_dispatch_fifo_empty || !i_dispatch_packet_available) begin
                    abort   = 1'b1;
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    rd_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet bookkeeping: size/mask capture, issued/written/emitted counts.
    always_comb begin
        total_d    = total_q;
        mask_d     = mask_q;
        issued_d   = issued_q;
        wr_cnt_d   = wr_cnt_q;
        beat_cnt_d = beat_cnt_q;
        aborted_d  = aborted_q;
        inflight_d = rd_en;
        if (state_q == ST_LATCH) begin
            total_d    = {1'b0, i_dispatch_counter} + CNT_ONE;
            mask_d     = i_dispatch_data_valid;
            issued_d   = '0;
            wr_cnt_d   = '0;
            beat_cnt_d = '0;
            aborted_d  = 1'b0;
        end else begin
            if (rd_en)      issued_d   = issued_q + CNT_ONE;
            if (inflight_q) wr_cnt_d   = wr_cnt_q + CNT_ONE;
            if (beat_fire)  beat_cnt_d = beat_cnt_q + CNT_ONE;
            if (abort)      aborted_d  = 1'b1;
        end
    end

    // Control registers; reset returns to IDLE without a discard pulse.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q    <= ST_IDLE;
            total_q    <= '0;
            mask_q     <= '0;
            issued_q   <= '0;
            wr_cnt_q   <= '0;
            beat_cnt_q <= '0;
            aborted_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            mask_q     <= mask_d;
            issued_q   <= issued_d;
            wr_cnt_q   <= wr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            aborted_q  <= aborted_d;
            inflight_q <= inflight_d;
        end
    end

    // The word arriving now is the wr_cnt_q-th of the packet; only the
    // packet's final index carries last and the latched byte mask.
    assign wr_last      = (wr_cnt_q == total_q - CNT_ONE);
    assign wr_keep      = wr_last ? mask_q : KEEP_ALL;
    assign obuf_wr_data = {i_dispatch_fifo_rd_data, wr_keep, wr_last};

    nts_backend_obuf #(
        .DEPTH (OBUF_DEPTH),
        .WIDTH (OBUF_W)
    ) u_obuf (
        .i_clk     (i_clk),
        .i_areset  (i_areset),
        .i_wr_en   (inflight_q),
        .i_wr_data (obuf_wr_data),
        .i_rd_en   (beat_fire),
        .o_rd_data (obuf_rd_data),
        .o_count   (obuf_count),
        .o_empty   (obuf_empty)
    );

    // After an abort the last word actually read becomes the packet end.
    assign force_last = (aborted_q || abort) && (beat_cnt_q == issued_q - CNT_ONE);

    // Outputs are gated by valid so an empty or reset buffer drives zeros.
    assign o_engine_valid = !obuf_empty;
    assign o_engine_data  = obuf_empty ? 64'd0 : obuf_rd_data[OBUF_W-1:9];
    assign o_engine_keep  = obuf_empty ? 8'd0  : obuf_rd_data[8:1];
    assign o_engine_last  = !obuf_empty && (obuf_rd_data[0] || force_last);

    assign o_dispatch_fifo_rd_en          = rd_en;
    assign o_dispatch_packet_read_discard = (state_q == ST_DISCARD);
    assign o_error                        = (state_q == ST_DISCARD) && aborted_q;

`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
    logic [31:0] stat_packets_q, stat_packets_d;
    logic [31:0] stat_aborts_q, stat_aborts_d;

    // Count completed and aborted packets once per discard, saturating.
    always_comb begin
        stat_packets_d = stat_packets_q;
        stat_aborts_d  = stat_aborts_q;
        if (state_q == ST_DISCARD) begin
            if (aborted_q) stat_aborts_d  = sat_inc32(stat_aborts_q);
            else           stat_packets_d = sat_inc32(stat_packets_q);
        end
    end

    // Statistics registers.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            stat_packets_q <= '0;
            stat_aborts_q  <= '0;
        end else begin
            stat_packets_q <= stat_packets_d;
            stat_aborts_q  <= stat_aborts_d;
        end
    end

    assign o_stat_packets = stat_packets_q;
    assign o_stat_aborts  = stat_aborts_q;
`endif

endmodule

// File: tb/tb_nts_dispatcher_backend.sv
// tb_nts_dispatcher_backend: directed scenarios with random payloads and
// random engine back-pressure, checked against a packet-level model.
module tb_nts_dispatcher_backend;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          i_areset;
    logic          i_dispatch_packet_available;
    logic          o_dispatch_packet_read_discard;
    logic [AW-1:0] i_dispatch_counter;
    logic [7:0]    i_dispatch_data_valid;
    logic          i_dispatch_fifo_empty;
    logic          o_dispatch_fifo_rd_en;
    logic [63:0]   i_dispatch_fifo_rd_data;
    logic          o_engine_valid;
    logic          i_engine_ready;
    logic [63:0]   o_engine_data;
    logic [7:0]    o_engine_keep;
    logic          o_engine_last;
    logic          o_error;
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
    logic [31:0]   o_stat_packets;
    logic [31:0]   o_stat_aborts;
`endif

    always #5 clk = ~clk;

    nts_dispatcher_backend #(.ADDR_WIDTH(AW), .OBUF_DEPTH(DEPTH)) dut (
        .i_clk                          (clk),
        .i_areset                       (i_areset),
        .i_dispatch_packet_available    (i_dispatch_packet_available),
        .o_dispatch_packet_read_discard (o_dispatch_packet_read_discard),
        .i_dispatch_counter             (i_dispatch_counter),
        .i_dispatch_data_valid          (i_dispatch_data_valid),
        .i_dispatch_fifo_empty          (i_dispatch_fifo_empty),
        .o_dispatch_fifo_rd_en          (o_dispatch_fifo_rd_en),
        .i_dispatch_fifo_rd_data        (i_dispatch_fifo_rd_data),
        .o_engine_valid                 (o_engine_valid),
        .i_engine_ready                 (i_engine_ready),
        .o_engine_data                  (o_engine_data),
        .o_engine_keep                  (o_engine_keep),
        .o_engine_last                  (o_engine_last),
        .o_error                        (o_error)
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        ,
        .o_stat_packets                 (o_stat_packets),
        .o_stat_aborts                  (o_stat_aborts)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Dispatcher model: all packet words back to back, one header per packet.
    logic [63:0] words[$];
    int          pstart[$];
    int          hdr_cnt[$];
    logic [7:0]  hdr_mask[$];
    // Expected and observed engine beats.
    logic [63:0] exp_d[$];
    logic [7:0]  exp_k[$];
    logic        exp_l[$];
    logic [63:0] got_d[$];
    logic [7:0]  got_k[$];
    logic        got_l[$];
    // Event log.
    int first_rd_q[$];
    int disc_cyc_q[$];
    int rd_idx, n_reads, n_beats, abort_after, cyc;
    int disc_cnt, err_cnt, stall_bad, max_out, ready_mode;
    bit new_pkt, stalled_prev;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic present_header();
        i_dispatch_packet_available = 1'b1;
        i_dispatch_counter          = AW'(hdr_cnt[0]);
        i_dispatch_data_valid       = hdr_mask[0];
    endtask

    // Queue an n-word packet; abort_k>0 means the dispatcher runs dry after abort_k reads.
    task automatic enqueue(input int n, input logic [7:0] mask, input int abort_k);
        logic [63:0] w;
        pstart.push_back(words.size());
        hdr_cnt.push_back(n - 1);
        hdr_mask.push_back(mask);
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            words.push_back(w);
            if (abort_k == 0) begin
                exp_d.push_back(w);
                exp_k.push_back((i == n - 1) ? mask : 8'hff);
                exp_l.push_back(i == n - 1);
            end else if (i < abort_k) begin
                exp_d.push_back(w);
                exp_k.push_back(8'hff);
                exp_l.push_back(i == abort_k - 1);
            end
        end
        if (hdr_cnt.size() == 1) present_header();
    endtask

    // One clock: sample outputs at the falling edge, then update the
    // dispatcher/engine model just after the rising edge.
    task automatic tick();
        bit rd_now, disc_now;
        @(negedge clk);
        rd_now   = o_dispatch_fifo_rd_en;
        disc_now = o_dispatch_packet_read_discard;
        if (rd_now && new_pkt) begin
            first_rd_q.push_back(cyc);
            new_pkt = 1'b0;
        end
        if (n_reads + int'(rd_now) - n_beats > max_out) max_out = n_reads + int'(rd_now) - n_beats;
        if (stalled_prev && !(o_engine_valid && o_engine_data === pd &&
                              o_engine_keep === pk && o_engine_last === pl)) stall_bad++;
        stalled_prev = o_engine_valid && !i_engine_ready;
        pd = o_engine_data;
        pk = o_engine_keep;
        pl = o_engine_last;
        if (o_engine_valid && i_engine_ready) begin
            got_d.push_back(o_engine_data);
            got_k.push_back(o_engine_keep);
            got_l.push_back(o_engine_last);
            n_beats++;
        end
        if (disc_now) begin
            disc_cnt++;
            disc_cyc_q.push_back(cyc);
            new_pkt = 1'b1;
        end
        if (o_error) err_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_now) begin
            i_dispatch_fifo_rd_data = (rd_idx < words.size()) ? words[rd_idx] : {$urandom, $urandom};
            rd_idx++;
            n_reads++;
            if (abort_after > 0 && n_reads == abort_after) i_dispatch_fifo_empty = 1'b1;
        end else begin
            i_dispatch_fifo_rd_data = {$urandom, $urandom};
        end
        if (disc_now) begin
            if (hdr_cnt.size() > 0) begin
                void'(hdr_cnt.pop_front());
                void'(hdr_mask.pop_front());
                void'(pstart.pop_front());
            end
            i_dispatch_fifo_empty = 1'b0;
            abort_after = 0;
            if (hdr_cnt.size() > 0) begin
                rd_idx = pstart[0];
                present_header();
            end else begin
                i_dispatch_packet_available = 1'b0;
            end
        end
        case (ready_mode)
            0:       i_engine_ready = 1'b1;
            1:       i_engine_ready = !i_engine_ready;
            2:       i_engine_ready = 1'($urandom_range(0, 1));
            default: i_engine_ready = 1'b0;
        endcase
    endtask

    task automatic reset_all();
        i_areset = 1'b1;
        i_dispatch_packet_available = 1'b0;
        i_dispatch_counter = '0;
        i_dispatch_data_valid = '0;
        i_dispatch_fifo_empty = 1'b0;
        i_dispatch_fifo_rd_data = '0;
        i_engine_ready = 1'b0;
        words.delete(); pstart.delete(); hdr_cnt.delete(); hdr_mask.delete();
        exp_d.delete(); exp_k.delete(); exp_l.delete();
        got_d.delete(); got_k.delete(); got_l.delete();
        first_rd_q.delete(); disc_cyc_q.delete();
        rd_idx = 0; n_reads = 0; n_beats = 0; abort_after = 0;
        disc_cnt = 0; err_cnt = 0; stall_bad = 0; max_out = 0;
        new_pkt = 1'b1; stalled_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_areset = 1'b0;
    endtask

    task automatic wait_discards(input string tag, input int target, input int budget);
        int n = 0;
        while (disc_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 80'(disc_cnt >= target), 80'd1);
        repeat (3) tick();
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_beats"}, 80'(got_d.size()), 80'(exp_d.size()));
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), {got_d[i], got_k[i], got_l[i]},
                  {exp_d[i], exp_k[i], exp_l[i]});
    endtask

    int lat;

    initial begin
        cyc = 0;
        ready_mode = 0;
        // Reset state: everything low while reset is held.
        i_areset = 1'b1;
        i_dispatch_packet_available = 1'b1;
        i_dispatch_counter = AW'(3);
        i_dispatch_data_valid = 8'h5a;
        i_dispatch_fifo_empty = 1'b0;
        i_dispatch_fifo_rd_data = {$urandom, $urandom};
        i_engine_ready = 1'b1;
        @(negedge clk);
        check("reset_outputs", {o_dispatch_fifo_rd_en, o_engine_valid, o_engine_data, o_engine_keep,
              o_engine_last, o_dispatch_packet_read_discard, o_error}, 80'd0);
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        check("reset_stats", {o_stat_packets, o_stat_aborts}, 80'd0);
`endif
        reset_all();

        // 5-word packet, mask 0f, ready held high.
        ready_mode = 0; i_engine_ready = 1'b1;
        enqueue(5, 8'h0f, 0);
        wait_discards("t1", 1, 40);
        compare_beats("t1");
        check("t1_discards", 80'(disc_cnt), 80'd1);
        check("t1_errors", 80'(err_cnt), 80'd0);
        lat = (first_rd_q.size() > 0 && disc_cyc_q.size() > 0) ? disc_cyc_q[0] - (first_rd_q[0] - 1) : 99;
        check("t1_latency_le_9", 80'(lat <= 9), 80'd1);

        // Single-word packet.
        reset_all();
        ready_mode = 0; i_engine_ready = 1'b1;
        enqueue(1, 8'h03, 0);
        wait_discards("t2", 1, 40);
        compare_beats("t2");
        check("t2_discards", 80'(disc_cnt), 80'd1);

        // 12 words with ready toggling every cycle.
        reset_all();
        ready_mode = 1; i_engine_ready = 1'b1;
        enqueue(12, 8'h7f, 0);
        wait_discards("t3", 1, 200);
        compare_beats("t3");
        check("t3_stall_stable", 80'(stall_bad), 80'd0);
        check("t3_credit", 80'(max_out <= DEPTH), 80'd1);

        // Dispatcher runs dry after 3 of 6 reads.
        reset_all();
        ready_mode = 0; i_engine_ready = 1'b1;
        abort_after = 3;
        enqueue(6, 8'h1f, 3);
        wait_discards("t4", 1, 60);
        compare_beats("t4");
        check("t4_errors", 80'(err_cnt), 80'd1);
        check("t4_discards", 80'(disc_cnt), 80'd1);
        check("t4_reads", 80'(n_reads), 80'd3);
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        check("t4_stat_aborts", 80'(o_stat_aborts), 80'd1);
        check("t4_stat_packets", 80'(o_stat_packets), 80'd0);
`endif

        // Reset in the middle of READ, then a clean packet.
        reset_all();
        ready_mode = 3; i_engine_ready = 1'b0;
        enqueue(12, 8'hf0, 0);
        for (int i = 0; i < 30 && n_reads < 3; i++) tick();
        check("t5_reads_started", 80'(n_reads >= 3), 80'd1);
        i_areset = 1'b1;
        @(negedge clk);
        check("t5_reset_outputs", {o_dispatch_fifo_rd_en, o_engine_valid, o_engine_data, o_engine_keep,
              o_engine_last, o_dispatch_packet_read_discard, o_error}, 80'd0);
        disc_cnt = 0;
        repeat (3) tick();
        check("t5_no_discard", 80'(disc_cnt), 80'd0);
        reset_all();
        ready_mode = 0; i_engine_ready = 1'b1;
        enqueue(7, 8'h01, 0);
        wait_discards("t5", 1, 60);
        compare_beats("t5");
        check("t5_discards", 80'(disc_cnt), 80'd1);

        // Two back-to-back packets under random back-pressure.
        reset_all();
        ready_mode = 2; i_engine_ready = 1'b1;
        enqueue(4, 8'h3f, 0);
        enqueue(9, 8'h07, 0);
        wait_discards("t6", 2, 300);
        compare_beats("t6");
        check("t6_relatch_gap", 80'((first_rd_q.size() > 1 && disc_cyc_q.size() > 0) ?
              first_rd_q[1] - disc_cyc_q[0] : -1), 80'd3);
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        check("t6_stat_packets", 80'(o_stat_packets), 80'd2);
`endif

        // Random packet train.
        reset_all();
        ready_mode = 2; i_engine_ready = 1'b0;
        for (int p = 0; p < 5; p++)
            enqueue(int'($urandom_range(1, 16)), 8'($urandom_range(1, 255)), 0);
        wait_discards("t7", 5, 900);
        compare_beats("t7");
        check("t7_errors", 80'(err_cnt), 80'd0);
        check("t7_stall_stable", 80'(stall_bad), 80'd0);
        check("t7_credit", 80'(max_out <= DEPTH), 80'd1);
`ifdef NTS_DISPATCHER_BACKEND_STATS_EN
        check("t7_stat_packets", 80'(o_stat_packets), 80'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nts_dispatcher_backend.md
NTS_DISPATCHER_BACKEND -- requirements
Module: nts_dispatcher_backend

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the dispatcher buffer address width.
REQ-002 SHALL have parameter OBUF_DEPTH, default 4, the output buffer depth in 64-bit words (power of 2, minimum 2).
REQ-003 SHALL have ports:
- i_clk  in  1  clock.
- i_areset  in  1  reset, asynchronous, active-high.
- i_dispatch_packet_available  in  1  a packet is ready in the dispatcher.
- o_dispatch_packet_read_discard  out  1  one-cycle pulse that releases the dispatcher buffer.
- i_dispatch_counter  in  ADDR_WIDTH  index of the last word (number of words = counter+1).
- i_dispatch_data_valid  in  8  byte-valid mask of the last word.
- i_dispatch_fifo_empty  in  1  dispatcher read side is exhausted.
- o_dispatch_fifo_rd_en  out  1  read-word strobe.
- i_dispatch_fifo_rd_data  in  64  read word; valid on the cycle after the rd_en that requested it.
- o_engine_valid  out  1  output word valid.
- i_engine_ready  in  1  engine accepts the word.
- o_engine_data  out  64  packet word.
- o_engine_keep  out  8  byte mask: 8'hff on every word except the last, which carries the latched i_dispatch_data_valid.
- o_engine_last  out  1  marks the final word of the packet.
- o_error  out  1  one-cycle pulse when a packet is aborted.

Function
REQ-004 SHALL implement the FSM IDLE, LATCH, READ, DRAIN, DISCARD.
REQ-005 In IDLE with i_dispatch_packet_available=1, the FSM SHALL move to LATCH.
REQ-006 LATCH SHALL capture words_total=i_dispatch_counter+1 (ADDR_WIDTH+1 bits, no wrap) and the last-word mask, then go to READ.
REQ-007 READ SHALL assert o_dispatch_fifo_rd_en only when (buffered words + in-flight reads) < OBUF_DEPTH and issued < words_total.
REQ-008 Every rd_en SHALL cause the word on i_dispatch_fifo_rd_data one cycle later to be written into the output buffer; no word may be lost or duplicated.
REQ-009 When issued == words_total, the FSM SHALL go to DRAIN.
REQ-010 DRAIN SHALL wait until the output buffer is empty and the last word has completed its handshake, then go to DISCARD.
REQ-011 DISCARD SHALL pulse o_dispatch_packet_read_discard for exactly one cycle, then return to IDLE.
REQ-012 The earliest next LATCH SHALL occur two cycles after the discard pulse, so the dispatcher's state update is seen first.
REQ-013 Output handshake SHALL be valid/ready: a word transfers when o_engine_valid && i_engine_ready.
REQ-014 While o_engine_valid=1 and i_engine_ready=0, the data, keep and last outputs SHALL be held stable.
REQ-015 o_engine_last and the latched mask SHALL accompany only word words_total-1.
REQ-016 A single-word packet (counter=0) SHALL produce one beat with last=1 and keep equal to the latched mask.
REQ-017 Abort: if i_dispatch_fifo_empty=1 or i_dispatch_packet_available=0 in READ before all words are issued, the block SHALL:
- stop reading;
- emit the already-buffered words, with last=1 forced on the final one;
- pulse o_error;
- go to DISCARD.
REQ-018 With i_engine_ready held high and no abort, a packet of N words SHALL complete within N+4 cycles of LATCH.

Reset
REQ-019 Asserting i_areset SHALL immediately force IDLE, empty the buffer, clear the counters, and drive every output to 0.
REQ-020 Reset asserted mid-packet SHALL NOT issue a discard pulse; the dispatcher is reset by the same signal.

Configuration
REQ-021 With NTS_DISPATCHER_BACKEND_STATS_EN defined, the block SHALL add:
- o_stat_packets (32-bit): increments on each DISCARD without abort;
- o_stat_aborts (32-bit): increments on each o_error;
- both saturate at 32'hffffffff and reset to 0.
REQ-022 Without NTS_DISPATCHER_BACKEND_STATS_EN, these ports and their counters SHALL NOT exist.

Structure
REQ-023 FSM state encodings and the keep constant 8'hff SHALL be defined in shared package nts_dispatcher_pkg.
REQ-024 The output buffer SHALL be the sub-module nts_backend_obuf: a synchronous FIFO of depth OBUF_DEPTH, width 64+8+1, with a registered count output.

Verification
REQ-025 The bench SHALL cover these scenarios:
- 5-word packet, counter=4, mask=8'h0f, ready=1 -> 5 beats in order; last and keep=8'h0f on beat 5; one discard pulse; done within 9 cycles.
- counter=0, mask=8'h03 -> one beat with last=1, keep=8'h03, then discard.
- 12-word packet, ready toggled 1/0 every cycle -> no loss, duplicate or data change while stalled; rd_en never exceeds buffer credit.
- fifo_empty asserted after 3 reads of a 6-word packet -> 3 beats, last on beat 3, o_error pulse, discard, o_stat_aborts=1 (STATS_EN).
- i_areset asserted mid-READ -> all outputs 0 next cycle; no discard pulse; next packet read cleanly.
- Two back-to-back packets -> second LATCH two cycles after first discard; with STATS_EN, o_stat_packets=2.
